seq_adder: RTL

Parametrised multi-cycle adder/subtractor. It processes CHUNK bits per clock, LSB chunk first, through a CHUNK-bit ripple of full-adder cells. A single carry flip-flop links consecutive chunks. It is the sequential, width-generic successor of the 1-bit full adder and reuses that cell's sum/carry equations per bit, with a start/busy/done handshake for use by datapath controllers.

---
 rtl/seq_adder_if.sv | 26 ++
 rtl/seq_adder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seq_adder_if.sv
// Handshake and operand/result bundle for seq_adder.
// The master side issues operations and the slave side returns results.
interface seq_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, x, y,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, cin, x, y,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with a single carry flop linking consecutive chunks.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input logic        clk,
    input logic        rst_n,
    seq_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (WIDTH < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK-1:0] sum_c;
    logic [CHUNK:0]   cy;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;

    // Ripple of full-adder cells over the low chunk of the operands
    always_comb begin
        sum_c = '0;
        cy    = '0;
        cy[0] = c_q;
        for (int i = 0; i < CHUNK; i++) begin
            sum_c[i]  = a_q[i] ^ b_q[i] ^ cy[i];
            cy[i + 1] = (a_q[i] & b_q[i]) | (cy[i] & (a_q[i] ^ b_q[i]));
        end
    end

    if (NCH == 1) begin : g_single
        assign a_sh = '0;
        assign b_sh = '0;
        assign r_sh = sum_c;
    end else begin : g_multi
        assign a_sh = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
        assign b_sh = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
        assign r_sh = {sum_c, r_q[WIDTH-1:CHUNK]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.x;
                    b_d     = bus.sub ? ~bus.y : bus.y;
                    c_d     = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_sh;
                b_d   = b_sh;
                r_d   = r_sh;
                c_d   = cy[CHUNK];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NCH - 1)) begin
                    s_d     = r_sh;
                    cout_d  = cy[CHUNK];
                    ovf_d   = cy[CHUNK] ^ cy[CHUNK-1];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
